// File: rtl/loss_pkg.sv
// Shared types and constants for the loss-unit producer path.
package loss_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_BITS = 8;

  typedef logic signed [DATA_W-1:0] fix_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/loss_feeder_if.sv
// Activation stream from the last systolic row and H/Y pair stream to the loss unit.
// master = loss_feeder side, slave = array/loss-unit side.
interface loss_feeder_if;
  import loss_pkg::*;

  fix_t act_1_in;
  fix_t act_2_in;
  logic act_valid_1_in;
  logic act_valid_2_in;
  fix_t H_1_out;
  fix_t Y_1_out;
  fix_t H_2_out;
  fix_t Y_2_out;
  logic valid_1_out;
  logic valid_2_out;

  modport master (
    input  act_1_in, act_2_in, act_valid_1_in, act_valid_2_in,
    output H_1_out, Y_1_out, H_2_out, Y_2_out, valid_1_out, valid_2_out
  );

  modport slave (
    output act_1_in, act_2_in, act_valid_1_in, act_valid_2_in,
    input  H_1_out, Y_1_out, H_2_out, Y_2_out, valid_1_out, valid_2_out
  );

endinterface

// File: rtl/loss_recip_div.sv
// Sequential restoring divider: one quotient bit per cycle, DATA_W cycles per divide.
// o_done_c/o_quotient_c are combinational and valid in the final iteration cycle.
module loss_recip_div
  import loss_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_done_c,
  output logic [DATA_W-1:0] o_quotient_c
);

  localparam int unsigned CW = $clog2(DATA_W) + 1;

  logic              r_busy;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_den;

  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;

  // One restoring step: shift in next dividend bit, subtract divisor if it fits.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
    w_diff    = w_rem_sh - {1'b0, r_den};
    w_ge      = ~w_diff[DATA_W];
    w_rem_nxt = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    w_quo_nxt = {r_quo[DATA_W-2:0], w_ge};
  end

  assign o_done_c     = r_busy && (r_cnt == CW'(1));
  assign o_quotient_c = w_quo_nxt;

  // Iteration registers; quotient shifts in from the dividend's vacated bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(DATA_W);
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_den  <= i_divisor;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_quo  <= w_quo_nxt;
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/loss_feeder.sv
// Pairs skewed activations with buffered per-column targets and feeds the loss unit.
// Optional feature macro: LOSS_FEEDER_INV_BATCH_EN (on-chip 2/N divider; otherwise 2/N is an input).
module loss_feeder
  import loss_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FRAC_BITS = loss_pkg::FRAC_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [DATA_W-1:0] batch_size_in,
  input  logic              tgt_wr_en_in,
  input  fix_t              tgt_1_in,
  input  fix_t              tgt_2_in,
  output logic              tgt_full_out,
`ifndef LOSS_FEEDER_INV_BATCH_EN
  input  fix_t              inv_batch_size_times_two_in,
`endif
  output fix_t              inv_batch_size_times_two_out,
  output logic              busy_out,
  output logic              batch_done_out,
  output logic              err_underflow_out,
  output logic              err_unexpected_out,
  loss_feeder_if.master     lif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FRAC_BITS + 2 > DATA_W) begin : g_bad_cfg
    $error("loss_feeder: DEPTH must be a power of two >= 2 and FRAC_BITS must fit 2/N");
  end

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_wr, r_rd1, r_rd2;
  fix_t              r_mem1 [DEPTH];
  fix_t              r_mem2 [DEPTH];
  logic [DATA_W-1:0] r_n, r_out_cnt;
  fix_t              r_h1, r_y1, r_h2, r_y2, r_inv;
  logic              r_v1, r_v2, r_full, r_busy, r_done, r_err_u, r_err_x;

  logic [PW-1:0]     w_cnt1, w_cnt2, w_wr_nxt, w_rd1_nxt, w_rd2_nxt;
  logic              w_start_ok, w_wr_en, w_take1, w_take2, w_under, w_unexp;
  logic              w_last, w_full_nxt;

`ifdef LOSS_FEEDER_INV_BATCH_EN
  localparam logic [DATA_W-1:0] DIVIDEND = DATA_W'(1) << (FRAC_BITS + 1);
  logic              w_div_done_c;
  logic [DATA_W-1:0] w_div_quo_c;

  loss_recip_div u_div (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start_ok),
    .i_dividend   (DIVIDEND),
    .i_divisor    (batch_size_in),
    .o_done_c     (w_div_done_c),
    .o_quotient_c (w_div_quo_c)
  );
`endif

  // Buffer occupancy, consume/error strobes and next pointer values.
  always_comb begin
    w_cnt1     = r_wr - r_rd1;
    w_cnt2     = r_wr - r_rd2;
    w_start_ok = start_in && (r_state == IDLE) && (batch_size_in != '0);
    w_wr_en    = tgt_wr_en_in && !r_full;
    w_take1    = (r_state == RUN) && lif.act_valid_1_in && (w_cnt1 != '0);
    w_take2    = (r_state == RUN) && lif.act_valid_2_in && (w_cnt2 != '0);
    w_under    = (r_state == RUN) &&
                 ((lif.act_valid_1_in && (w_cnt1 == '0)) ||
                  (lif.act_valid_2_in && (w_cnt2 == '0)));
    w_unexp    = (r_state != RUN) && (lif.act_valid_1_in || lif.act_valid_2_in);
    w_wr_nxt   = r_wr  + PW'(w_wr_en);
    w_rd1_nxt  = r_rd1 + PW'(w_take1);
    w_rd2_nxt  = r_rd2 + PW'(w_take2);
    w_full_nxt = ((w_wr_nxt - w_rd1_nxt) == PW'(DEPTH)) ||
                 ((w_wr_nxt - w_rd2_nxt) == PW'(DEPTH));
  end

  // Batch FSM next-state; w_last marks the final column-2 pair of the batch.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
`ifdef LOSS_FEEDER_INV_BATCH_EN
          w_state_nxt = CALC;
`else
          w_state_nxt = RUN;
`endif
        end
      end
      CALC: begin
`ifdef LOSS_FEEDER_INV_BATCH_EN
        if (w_div_done_c) w_state_nxt = RUN;
`else
        w_state_nxt = IDLE;
`endif
      end
      RUN: begin
        if (r_v2 && ((r_out_cnt + DATA_W'(1)) == r_n)) begin
          w_state_nxt = DONE;
          w_last      = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Target storage; contents are don't-care until the write pointer covers them.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem1[r_wr[AW-1:0]] <= tgt_1_in;
      r_mem2[r_wr[AW-1:0]] <= tgt_2_in;
    end
  end

  // Pointers, output pairs, batch bookkeeping and sticky errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr      <= '0;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_h1      <= '0;
      r_y1      <= '0;
      r_h2      <= '0;
      r_y2      <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_full    <= 1'b0;
      r_n       <= '0;
      r_out_cnt <= '0;
      r_inv     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err_u   <= 1'b0;
      r_err_x   <= 1'b0;
    end else begin
      r_wr   <= w_wr_nxt;
      r_rd1  <= w_rd1_nxt;
      r_rd2  <= w_rd2_nxt;
      r_full <= w_full_nxt;
      r_v1   <= w_take1;
      r_v2   <= w_take2;
      if (w_take1) begin
        r_h1 <= lif.act_1_in;
        r_y1 <= r_mem1[r_rd1[AW-1:0]];
      end
      if (w_take2) begin
        r_h2 <= lif.act_2_in;
        r_y2 <= r_mem2[r_rd2[AW-1:0]];
      end
      if (w_start_ok) begin
        r_n       <= batch_size_in;
        r_out_cnt <= '0;
`ifndef LOSS_FEEDER_INV_BATCH_EN
        r_inv     <= inv_batch_size_times_two_in;
`endif
      end else if ((r_state == RUN) && r_v2) begin
        r_out_cnt <= r_out_cnt + DATA_W'(1);
      end
`ifdef LOSS_FEEDER_INV_BATCH_EN
      if (w_div_done_c) r_inv <= fix_t'(w_div_quo_c);
`endif
      r_busy <= (w_state_nxt != IDLE);
      r_done <= w_last;
      if (w_under) r_err_u <= 1'b1;
      if (w_unexp) r_err_x <= 1'b1;
    end
  end

  assign tgt_full_out                 = r_full;
  assign inv_batch_size_times_two_out = r_inv;
  assign busy_out                     = r_busy;
  assign batch_done_out               = r_done;
  assign err_underflow_out            = r_err_u;
  assign err_unexpected_out           = r_err_x;
  assign lif.H_1_out                  = r_h1;
  assign lif.Y_1_out                  = r_y1;
  assign lif.H_2_out                  = r_h2;
  assign lif.Y_2_out                  = r_y2;
  assign lif.valid_1_out              = r_v1;
  assign lif.valid_2_out              = r_v2;

endmodule

// File: tb/tb_loss_feeder.sv
// Scoreboard bench for loss_feeder: a target FIFO model produces expected (H,Y) pairs
// at drive time; a negedge monitor pops and compares them when the DUT emits pairs.
module tb_loss_feeder;
  import loss_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        start_in;
  logic [15:0] batch_size_in;
  logic        tgt_wr_en_in;
  fix_t        tgt_1_in, tgt_2_in;
  logic        tgt_full_out;
  fix_t        inv_in;
  fix_t        inv_out;
  logic        busy_out, batch_done_out, err_underflow_out, err_unexpected_out;

  loss_feeder_if lif ();

  loss_feeder #(.DEPTH(DEPTH)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .start_in                     (start_in),
    .batch_size_in                (batch_size_in),
    .tgt_wr_en_in                 (tgt_wr_en_in),
    .tgt_1_in                     (tgt_1_in),
    .tgt_2_in                     (tgt_2_in),
    .tgt_full_out                 (tgt_full_out),
`ifndef LOSS_FEEDER_INV_BATCH_EN
    .inv_batch_size_times_two_in  (inv_in),
`endif
    .inv_batch_size_times_two_out (inv_out),
    .busy_out                     (busy_out),
    .batch_done_out               (batch_done_out),
    .err_underflow_out            (err_underflow_out),
    .err_unexpected_out           (err_unexpected_out),
    .lif                          (lif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m1[$];
  logic [15:0] m2[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every emitted pair must match the oldest expectation of its column.
  always @(negedge clk) begin
    if (rst && lif.valid_1_out) begin
      if (q1.size() == 0) check_eq("col1_extra_valid", 32'd1, 32'd0);
      else check_eq("col1_pair", {lif.H_1_out, lif.Y_1_out}, q1.pop_front());
    end
    if (rst && lif.valid_2_out) begin
      if (q2.size() == 0) check_eq("col2_extra_valid", 32'd1, 32'd0);
      else check_eq("col2_pair", {lif.H_2_out, lif.Y_2_out}, q2.pop_front());
    end
  end

  task automatic write_tgt(input logic [15:0] a, input logic [15:0] b);
    tgt_wr_en_in = 1'b1;
    tgt_1_in     = a;
    tgt_2_in     = b;
    if (m1.size() < DEPTH && m2.size() < DEPTH) begin
      m1.push_back(a);
      m2.push_back(b);
    end
    tick();
    tgt_wr_en_in = 1'b0;
  endtask

  // Drive one cycle of activations while in RUN; expectations come from the target model.
  task automatic drive(input logic v1, input logic [15:0] a1, input logic v2, input logic [15:0] a2);
    lif.act_valid_1_in = v1;
    lif.act_1_in       = a1;
    lif.act_valid_2_in = v2;
    lif.act_2_in       = a2;
    if (v1 && m1.size() > 0) q1.push_back({a1, m1.pop_front()});
    if (v2 && m2.size() > 0) q2.push_back({a2, m2.pop_front()});
  endtask

  task automatic start_batch(input logic [15:0] n, input logic [15:0] inv);
    logic [15:0] exp_inv;
    start_in      = 1'b1;
    batch_size_in = n;
    inv_in        = inv;
    tick();
    start_in = 1'b0;
`ifdef LOSS_FEEDER_INV_BATCH_EN
    repeat (16) tick();
    exp_inv = 16'(32'd512 / 32'(n));
`else
    exp_inv = inv;
`endif
    check_eq("inv_2_over_n", inv_out, exp_inv);
  endtask

  task automatic model_full_check(input string tag);
    check_eq(tag, 32'(tgt_full_out), 32'(m1.size() == DEPTH || m2.size() == DEPTH));
  endtask

  initial begin
    rst                = 1'b0;
    start_in           = 1'b0;
    batch_size_in      = '0;
    tgt_wr_en_in       = 1'b0;
    tgt_1_in           = '0;
    tgt_2_in           = '0;
    inv_in             = '0;
    lif.act_1_in       = '0;
    lif.act_2_in       = '0;
    lif.act_valid_1_in = 1'b0;
    lif.act_valid_2_in = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_full", 32'(tgt_full_out), 32'd0);
    check_eq("rst_busy", 32'(busy_out), 32'd0);
    check_eq("rst_done", 32'(batch_done_out), 32'd0);
    check_eq("rst_valids", {30'd0, lif.valid_1_out, lif.valid_2_out}, 32'd0);
    check_eq("rst_errs", {30'd0, err_underflow_out, err_unexpected_out}, 32'd0);
    check_eq("rst_inv", 32'(inv_out), 32'd0);
    rst = 1'b1;
    tick();

`ifdef LOSS_FEEDER_INV_BATCH_EN
    // Divider results for a few batch sizes; reset between runs to leave RUN.
    begin
      logic [15:0] ns [3];
      ns[0] = 16'd4; ns[1] = 16'd3; ns[2] = 16'd1;
      for (int k = 0; k < 3; k++) begin
        start_batch(ns[k], 16'h0);
        check_eq("calc_busy", 32'(busy_out), 32'd1);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
      end
    end
`endif

    // Basic skewed batch of two
    write_tgt(16'd10, 16'd20);
    write_tgt(16'd30, 16'd40);
    model_full_check("a_full");
    start_batch(16'd2, 16'h0080);
    check_eq("a_busy", 32'(busy_out), 32'd1);
    drive(1'b1, 16'd5, 1'b0, 16'd0);
    tick();
    check_eq("a_t1_valids", {30'd0, lif.valid_1_out, lif.valid_2_out}, 32'b10);
    drive(1'b1, 16'd5, 1'b1, 16'd7);
    tick();
    check_eq("a_t2_valids", {30'd0, lif.valid_1_out, lif.valid_2_out}, 32'b11);
    drive(1'b0, 16'd0, 1'b1, 16'd7);
    tick();
    check_eq("a_t3_valids", {30'd0, lif.valid_1_out, lif.valid_2_out}, 32'b01);
    check_eq("a_t3_done", 32'(batch_done_out), 32'd0);
    drive(1'b0, 16'd0, 1'b0, 16'd0);
    tick();
    check_eq("a_t4_done", 32'(batch_done_out), 32'd1);
    tick();
    check_eq("a_t5_done", 32'(batch_done_out), 32'd0);
    check_eq("a_t5_busy", 32'(busy_out), 32'd0);

    // Fill to DEPTH, drop a ninth write, then drain both columns
    for (int i = 0; i < DEPTH; i++) write_tgt(16'(100 + i), 16'(200 + i));
    check_eq("b_full_at_depth", 32'(tgt_full_out), 32'd1);
    write_tgt(16'd999, 16'd999);
    check_eq("b_full_after_drop", 32'(tgt_full_out), 32'd1);
    start_batch(16'd8, 16'h0040);
    drive(1'b1, 16'd1, 1'b0, 16'd0);
    tick();
    check_eq("b_full_after_col1", 32'(tgt_full_out), 32'd1);
    drive(1'b0, 16'd0, 1'b1, 16'd2);
    tick();
    check_eq("b_full_after_col2", 32'(tgt_full_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(i < 7, 16'(3 + i), i >= 1, 16'(50 + i));
      tick();
    end
    drive(1'b0, 16'd0, 1'b0, 16'd0);
    tick();
    check_eq("b_done", 32'(batch_done_out), 32'd1);
    tick();
    check_eq("b_idle", 32'(busy_out), 32'd0);
    model_full_check("b_full_end");

    // Underflow in RUN with an empty buffer
    start_batch(16'd1, 16'h0011);
    check_eq("c_err_u_before", 32'(err_underflow_out), 32'd0);
    drive(1'b1, 16'd9, 1'b0, 16'd0);
    tick();
    check_eq("c_no_valid", 32'(lif.valid_1_out), 32'd0);
    check_eq("c_err_u", 32'(err_underflow_out), 32'd1);
    drive(1'b0, 16'd0, 1'b0, 16'd0);
    tick();
    tick();
    check_eq("c_err_u_sticky", 32'(err_underflow_out), 32'd1);
    check_eq("c_err_x_clear", 32'(err_unexpected_out), 32'd0);

    // Reset mid-RUN with three queued targets
    write_tgt(16'd1, 16'd2);
    write_tgt(16'd3, 16'd4);
    write_tgt(16'd5, 16'd6);
    model_full_check("d_full_3");
    rst = 1'b0;
    #1;
    m1.delete();
    m2.delete();
    check_eq("d_rst_full", 32'(tgt_full_out), 32'd0);
    check_eq("d_rst_busy", 32'(busy_out), 32'd0);
    check_eq("d_rst_errs", {30'd0, err_underflow_out, err_unexpected_out}, 32'd0);
    check_eq("d_rst_h1y1", {lif.H_1_out, lif.Y_1_out}, 32'd0);
    check_eq("d_rst_h2y2", {lif.H_2_out, lif.Y_2_out}, 32'd0);
    check_eq("d_rst_inv", 32'(inv_out), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Activation in IDLE and a zero-size start
    lif.act_valid_2_in = 1'b1;
    lif.act_2_in       = 16'd33;
    tick();
    lif.act_valid_2_in = 1'b0;
    check_eq("e_err_x", 32'(err_unexpected_out), 32'd1);
    check_eq("e_no_valid2", 32'(lif.valid_2_out), 32'd0);
    start_in      = 1'b1;
    batch_size_in = 16'd0;
    tick();
    start_in = 1'b0;
    tick();
    check_eq("e_n0_busy", 32'(busy_out), 32'd0);
    start_batch(16'd1, 16'h0022);
    check_eq("e_busy", 32'(busy_out), 32'd1);
    drive(1'b1, 16'd4, 1'b0, 16'd0);
    tick();
    drive(1'b0, 16'd0, 1'b0, 16'd0);
    check_eq("e_post_rst_no_valid", 32'(lif.valid_1_out), 32'd0);
    check_eq("e_post_rst_underflow", 32'(err_underflow_out), 32'd1);
    tick();

    check_eq("sb_col1_drained", 32'(q1.size()), 32'd0);
    check_eq("sb_col2_drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
